// File: rtl/cond_pkg.sv
// Shared types for the condition/flag unit: condition codes, FSM states,
// NZCV bit positions and the latched instruction control bundle.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE
   } cond_e;

   typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, EXEC = 2'd2} state_e;

   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   typedef struct packed {
      logic [3:0] cond;
      logic [1:0] flag_w;
      logic       pcs;
      logic       reg_w;
      logic       mem_w;
      logic       no_write;
   } instr_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluation against an NZCV flag vector.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FN];
   assign z = flags[FZ];
   assign c = flags[FC];
   assign v = flags[FV];

   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         EQ: cond_ex = z;
         NE: cond_ex = ~z;
         CS: cond_ex = c;
         CC: cond_ex = ~c;
         MI: cond_ex = n;
         PL: cond_ex = ~n;
         VS: cond_ex = v;
         VC: cond_ex = ~v;
         HI: cond_ex = c & ~z;
         LS: cond_ex = ~c | z;
         GE: cond_ex = (n == v);
         LT: cond_ex = (n != v);
         GT: cond_ex = ~z & (n == v);
         LE: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;   // AL and the reserved 0xF both execute
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Condition/flag unit: NZCV register, IDLE->EVAL->EXEC sequencing and write-strobe gating.
// Optional squash counter enabled by defining COND_SKIPCNT_EN.
module cond_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue,
   input  logic [3:0]       cond,
   input  logic [1:0]       flag_w,
   input  logic             pcs,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             no_write,
   input  logic [3:0]       alu_flags,
   input  logic             exec_done,
   output logic             busy,
   output logic             cond_ex,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_write,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] skip_count
);

   state_e state;
   instr_t ir;
   logic   eval_ex;
   logic   done_now;

   cond_eval u_eval (
      .cond    (ir.cond),
      .flags   (flags),
      .cond_ex (eval_ex)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ir      <= '0;
         flags   <= '0;
         cond_ex <= 1'b0;
      end else begin
         case (state)
            IDLE: if (issue) begin
               ir    <= '{cond: cond, flag_w: flag_w, pcs: pcs, reg_w: reg_w,
                          mem_w: mem_w, no_write: no_write};
               state <= EVAL;
            end
            EVAL: begin
               cond_ex <= eval_ex;
               state   <= eval_ex ? EXEC : IDLE;
            end
            EXEC: if (exec_done) begin
               if (ir.flag_w[1]) begin
                  flags[FN] <= alu_flags[FN];
                  flags[FZ] <= alu_flags[FZ];
               end
               if (ir.flag_w[0]) begin
                  flags[FC] <= alu_flags[FC];
                  flags[FV] <= alu_flags[FV];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done_now  = (state == EXEC) & exec_done;
   // Strobes fire only in the completion cycle; compares never touch the register file
   assign pc_src    = done_now & ir.pcs;
   assign reg_write = done_now & ir.reg_w & ~ir.no_write;
   assign mem_write = done_now & ir.mem_w;

`ifdef COND_SKIPCNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         skip_count <= '0;
      else if (state == EVAL && !eval_ex)
         skip_count <= skip_count + CNT_W'(1);
   end
`else
   assign skip_count = '0;
`endif

endmodule
